// File: rtl/msb_first_serializer.sv
// MSB-first parallel-to-serial converter with a one-word hold buffer so that
// consecutive words stream with no idle cycles between them.
module msb_first_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_data;
    logic [CW-1:0]    cnt;
    logic             hold_valid;
    logic             accept;
    logic             advance;
    logic             end_of_word;
    logic             bypass;
    logic             fill_hold;

    assign in_ready    = ~hold_valid;
    assign accept      = in_valid & in_ready;
    assign advance     = (state == SHIFT) & ser_ready;
    assign end_of_word = advance & (cnt == '0);
    // A word arriving exactly as the current one ends goes straight to shreg.
    assign bypass      = end_of_word & ~hold_valid & accept;
    assign fill_hold   = (state == SHIFT) & accept & ~bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            hold_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= in_data;
                        cnt   <= CNT_MAX;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (advance) begin
                        if (cnt != '0) begin
                            shreg <= shreg << 1;
                            cnt   <= cnt - 1'b1;
                        end else if (hold_valid) begin
                            shreg      <= hold_data;
                            cnt        <= CNT_MAX;
                            hold_valid <= 1'b0;
                        end else if (accept) begin
                            shreg <= in_data;
                            cnt   <= CNT_MAX;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    if (fill_hold) begin
                        hold_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Hold payload carries no reset; hold_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (fill_hold) begin
            hold_data <= in_data;
        end
    end

    // Outputs are decodes of registers only, held naturally during a stall.
    assign ser_valid = (state == SHIFT);
    assign ser_bit   = (state == SHIFT) & shreg[WIDTH-1];
    assign ser_first = (state == SHIFT) & (cnt == CNT_MAX);
    assign ser_last  = (state == SHIFT) & (cnt == '0);
    assign busy      = (state == SHIFT) | hold_valid;

endmodule

// File: tb/tb_msb_first_serializer.sv
// Randomized and directed bench for msb_first_serializer, checked every cycle
// against a word-queue model of the serial stream.
module tb_msb_first_serializer;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       ser_ready;
    logic       ser_valid;
    logic       ser_bit;
    logic       ser_first;
    logic       ser_last;
    logic       busy;

    logic       v2;
    logic       ir2;
    logic [1:0] d2;
    logic       sr2;
    logic       sv2;
    logic       sb2;
    logic       sf2;
    logic       sl2;
    logic       bz2;

    int vectors = 0;
    int miscompares = 0;

    // Model: queue of words not yet fully sent; midx = bits of mq[0] consumed.
    logic [7:0] mq[$];
    int         midx = 0;
    logic [63:0] cap;

    msb_first_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ser_ready(ser_ready), .ser_valid(ser_valid),
        .ser_bit(ser_bit), .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
    );

    msb_first_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2),
        .in_data(d2), .ser_ready(sr2), .ser_valid(sv2),
        .ser_bit(sb2), .ser_first(sf2), .ser_last(sl2), .busy(bz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic       ev, eb, ef, el;
        logic [7:0] w;
        ev = (mq.size() > 0);
        eb = 1'b0;
        ef = 1'b0;
        el = 1'b0;
        if (ev) begin
            w  = mq[0];
            eb = w[7-midx];
            ef = (midx == 0);
            el = (midx == 7);
        end
        chk("ser_valid", 64'(ser_valid), 64'(ev));
        chk("ser_bit", 64'(ser_bit), 64'(eb));
        chk("ser_first", 64'(ser_first), 64'(ef));
        chk("ser_last", 64'(ser_last), 64'(el));
        chk("busy", 64'(busy), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    endtask

    task automatic tick();
        logic acc, adv;
        acc = in_valid && (mq.size() < 2);
        adv = (mq.size() > 0) && ser_ready;
        if (ser_valid && ser_ready) cap = {cap[62:0], ser_bit};
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            midx = 0;
        end else begin
            if (adv) begin
                midx++;
                if (midx == 8) begin
                    mq.delete(0);
                    midx = 0;
                end
            end
            if (acc) mq.push_back(in_data);
        end
        #1;
        compare();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        mq.delete();
        midx = 0;
        compare();
    endtask

    initial begin
        logic [63:0] vv, ff, ll, bb;
        logic [7:0]  sw[3];
        logic        acc;
        int          k;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ser_ready = 1'b1;
        v2 = 1'b0; d2 = '0; sr2 = 1'b1;
        cap = '0;
        #2;
        compare();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single word 0xA5
        in_valid = 1'b1; in_data = 8'hA5; tick(); in_valid = 1'b0;
        vv = '0; ff = '0; ll = '0; bb = '0;
        for (int c = 1; c <= 9; c++) begin
            vv = {vv[62:0], ser_valid}; ff = {ff[62:0], ser_first};
            ll = {ll[62:0], ser_last};  bb = {bb[62:0], ser_bit};
            tick();
        end
        chk("a5_bits", bb, 64'b101001010);
        chk("a5_valid", vv, 64'b111111110);
        chk("a5_first", ff, 64'b100000000);
        chk("a5_last", ll, 64'b000000010);

        // Streaming three words with in_valid held high
        sw[0] = 8'h0F; sw[1] = 8'hF0; sw[2] = 8'h33;
        cap = '0; vv = '0; ff = '0; k = 0;
        in_valid = 1'b1; in_data = sw[0];
        for (int c = 0; c <= 25; c++) begin
            if (c >= 1) begin
                vv = {vv[62:0], ser_valid};
                ff = {ff[62:0], ser_first};
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                k++;
                if (k < 3) in_data = sw[k];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("stream_bits", cap, 64'h0FF033);
        chk("stream_valid", vv, 64'h1FFFFFE);
        chk("stream_first", ff, 64'h1010100);

        // Stall: ser_ready toggling
        in_valid = 1'b1; in_data = 8'h81; tick(); in_valid = 1'b0;
        cap = '0; vv = '0;
        for (int c = 1; c <= 16; c++) begin
            ser_ready = (c % 2 == 1);
            vv = {vv[62:0], ser_valid};
            tick();
        end
        ser_ready = 1'b1;
        chk("stall_bits", cap, 64'h81);
        chk("stall_span", vv, 64'hFFFE);

        // Bypass: next word offered during the last bit of the previous one
        cap = '0;
        in_valid = 1'b1; in_data = 8'h11; tick(); in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                chk("bypass_last", 64'(ser_last), 64'd1);
                in_valid = 1'b1; in_data = 8'h3C;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("bypass_first", 64'(ser_first), 64'd1);
        chk("bypass_msb", 64'(ser_bit), 64'd0);
        chk("bypass_hold_empty", 64'(in_ready), 64'd1);
        repeat (9) tick();
        chk("bypass_bits", cap, 64'h113C);

        // Reset mid-word with a word in the hold buffer
        in_valid = 1'b1; in_data = 8'hFF; tick();
        in_data = 8'h55; tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("midword_busy", 64'(busy), 64'd1);
        chk("midword_hold_full", 64'(in_ready), 64'd0);
        assert_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(ser_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        cap = '0;
        in_valid = 1'b1; in_data = 8'h12; tick(); in_valid = 1'b0;
        repeat (9) tick();
        chk("after_rst_bits", cap, 64'h0012);

        // WIDTH=2 instance: 2'b10 then 2'b01 back-to-back
        vv = '0; ff = '0; ll = '0; bb = '0;
        v2 = 1'b1; d2 = 2'b10;
        for (int c = 0; c <= 4; c++) begin
            tick();
            vv = {vv[62:0], sv2}; ff = {ff[62:0], sf2};
            ll = {ll[62:0], sl2}; bb = {bb[62:0], sb2};
            if (c == 0) d2 = 2'b01;
            if (c == 1) v2 = 1'b0;
        end
        chk("w2_bits", bb, 64'b10010);
        chk("w2_valid", vv, 64'b11110);
        chk("w2_first", ff, 64'b10100);
        chk("w2_last", ll, 64'b01010);

        // Randomized traffic, stalls and occasional resets
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                in_valid = 1'b0;
                assert_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        ser_ready = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
